mop_issue_stage: RTL and testbench

Register-read/issue stage of the Musk core. It sits between the decoder's micro-op queue and the execute stage. It owns the architectural register file and the register scoreboard, and holds each `micro_op_t` until its sources and destination are hazard-free. On issue it loads `src0_val`/`src1_val` into the micro-op and hands it to execute through a one-entry output register. It clears scoreboard bits on writeback and discards its held micro-op on a taken-branch flush.

---
 rtl/mop_issue_stage_if.sv | 62 ++++++
 rtl/mop_issue_stage.sv | 138 +++++++++++++
 tb/tb_mop_issue_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mop_issue_stage_if.sv
// Types shared by the issue stage and its neighbours, plus the handshake interface.
// Ports: in_* (decoder -> stage), out_* (stage -> execute), wb_* (writeback), flush.
// Backpressure: valid/ready on both the in_* and out_* sides; wb_* and flush are unconditional.
package mop_pkg;
  // Architectural register map: file registers occupy ids 0..reg_map_size-1,
  // pseudo-registers sit above the file and never touch rf/sb.
  localparam int unsigned reg_map_size = 16;

  typedef logic [4:0]  reg_id_t;
  typedef logic [63:0] reg_val_t;

  localparam reg_id_t rax      = 5'd0;
  localparam reg_id_t rbx      = 5'd1;
  localparam reg_id_t rcx      = 5'd2;
  localparam reg_id_t rdx      = 5'd3;
  localparam reg_id_t rsi      = 5'd4;
  localparam reg_id_t rdi      = 5'd5;
  localparam reg_id_t rbp      = 5'd6;
  localparam reg_id_t rsp      = 5'd7;
  localparam reg_id_t rnil     = 5'd16;
  localparam reg_id_t rv0      = 5'd17;
  localparam reg_id_t rv8      = 5'd18;
  localparam reg_id_t rip      = 5'd19;
  localparam reg_id_t rimm     = 5'd20;
  localparam reg_id_t rsyscall = 5'd21;

  typedef struct packed {
    logic [7:0] opcode;
    reg_id_t    dst;
    reg_id_t    src0;
    reg_id_t    src1;
    reg_val_t   immediate;
    reg_val_t   rip_val;
    reg_val_t   src0_val;
    reg_val_t   src1_val;
  } micro_op_t;
endpackage

interface mop_issue_stage_if;
  logic                 in_valid;
  logic                 in_ready;
  mop_pkg::micro_op_t   in_mop;
  logic                 out_valid;
  logic                 out_ready;
  mop_pkg::micro_op_t   out_mop;
  logic                 wb_valid;
  mop_pkg::reg_id_t     wb_id;
  mop_pkg::reg_val_t    wb_val;
  logic                 flush;

  // slave: the issue stage itself
  modport slave (
    input  in_valid, in_mop, out_ready, wb_valid, wb_id, wb_val, flush,
    output in_ready, out_valid, out_mop
  );

  // master: decoder/execute/writeback side driving the stage
  modport master (
    output in_valid, in_mop, out_ready, wb_valid, wb_id, wb_val, flush,
    input  in_ready, out_valid, out_mop
  );
endinterface

// File: rtl/mop_issue_stage.sv
// Register-read/issue stage: holds a micro-op until its ids are hazard-free, reads sources, issues.
// Latency: op accepted in cycle N is on out_* in N+1; 1 op/cycle when execute drains every cycle.
// Backpressure: in_ready low on hazard, flush, or full output slot not being consumed.
// Ports: clk, reset (async active-low), io (slave modport: in/out handshakes, writeback, flush),
//        issue_count/stall_count (64-bit event counters),
//        syscall_valid/syscall_rax (one-cycle syscall strobe carrying rax, raised only on issue).
module mop_issue_stage
  import mop_pkg::*;
#(
  parameter int unsigned REG_FILE_SIZE = reg_map_size
) (
  input  logic             clk,
  input  logic             reset,
  mop_issue_stage_if.slave io,
  output logic [63:0]      issue_count,
  output logic [63:0]      stall_count,
  output logic             syscall_valid,
  output reg_val_t         syscall_rax
);

  localparam int unsigned IW = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;

  typedef logic [REG_FILE_SIZE-1:0] mask_t;
  typedef enum logic {slot_empty, slot_full} slot_t;

  reg_val_t  rf [REG_FILE_SIZE];
  mask_t     sb, sb_d;
  mask_t     held_mask, held_d;
  slot_t     slot_q, slot_d;
  micro_op_t out_mop_q;
  micro_op_t issue_mop;

  logic  hazard_ok;
  logic  issue;
  logic  consume;
  logic  wb_hit;
  mask_t issue_mask;

  function automatic logic in_file(reg_id_t id);
    return 32'(id) < REG_FILE_SIZE;
  endfunction

  // rsyscall serialises: it waits for every outstanding write to land.
  function automatic logic id_blocked(reg_id_t id, mask_t s);
    if (in_file(id)) return s[IW'(id)];
    if (id == rsyscall) return |s;
    return 1'b0;
  endfunction

  function automatic mask_t dst_mask(reg_id_t id);
    mask_t m;
    m = '0;
    if (in_file(id)) m[IW'(id)] = 1'b1;
    return m;
  endfunction

  function automatic reg_val_t src_val(reg_id_t id, micro_op_t m, reg_val_t file_val);
    case (id)
      rnil, rv0: return '0;
      rv8:       return 64'd8;
      rip:       return m.rip_val;
      rimm:      return m.immediate;
      default:   return in_file(id) ? file_val : '0;
    endcase
  endfunction

  // Hazards are judged on the registered scoreboard; a same-cycle writeback does not bypass.
  assign hazard_ok = !(id_blocked(io.in_mop.src0, sb) ||
                       id_blocked(io.in_mop.src1, sb) ||
                       id_blocked(io.in_mop.dst,  sb));

  assign io.in_ready = !io.flush && hazard_ok && (slot_q == slot_empty || io.out_ready);
  assign issue       = io.in_valid && io.in_ready;
  assign consume     = (slot_q == slot_full) && io.out_ready;
  assign wb_hit      = io.wb_valid && in_file(io.wb_id);
  assign issue_mask  = dst_mask(io.in_mop.dst);

  always_comb begin
    issue_mop          = io.in_mop;
    issue_mop.src0_val = src_val(io.in_mop.src0, io.in_mop, rf[IW'(io.in_mop.src0)]);
    issue_mop.src1_val = src_val(io.in_mop.src1, io.in_mop, rf[IW'(io.in_mop.src1)]);
  end

  // rax is file register 0; with the scoreboard empty its file value is current.
  assign syscall_valid = issue && (io.in_mop.src0 == rsyscall || io.in_mop.src1 == rsyscall);
  assign syscall_rax   = rf[0];

  always_comb begin
    slot_d = slot_q;
    sb_d   = sb;
    held_d = held_mask;
    if (wb_hit) sb_d[IW'(io.wb_id)] = 1'b0;
    // A flushed op that execute did not take will never write back; release its dst.
    // If execute took it this same cycle it is live downstream and keeps its bit.
    if (io.flush && slot_q == slot_full && !io.out_ready) sb_d = sb_d & ~held_mask;
    // Set after clear so a same-bit writeback and issue leaves the bit set.
    if (issue) begin
      slot_d = slot_full;
      sb_d   = sb_d | issue_mask;
      held_d = issue_mask;
    end else if (io.flush || consume) begin
      slot_d = slot_empty;
      held_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q    <= slot_empty;
      sb        <= '0;
      held_mask <= '0;
    end else begin
      slot_q    <= slot_d;
      sb        <= sb_d;
      held_mask <= held_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_mop_q   <= '0;
      issue_count <= '0;
      stall_count <= '0;
      for (int i = 0; i < int'(REG_FILE_SIZE); i++) rf[i] <= '0;
    end else begin
      if (issue) begin
        out_mop_q   <= issue_mop;
        issue_count <= issue_count + 64'd1;
      end
      if (io.in_valid && !io.in_ready) stall_count <= stall_count + 64'd1;
      if (wb_hit) rf[IW'(io.wb_id)] <= io.wb_val;
    end
  end

  assign io.out_valid = (slot_q == slot_full);
  assign io.out_mop   = out_mop_q;

endmodule

// File: tb/tb_mop_issue_stage.sv
module tb_mop_issue_stage;
  import mop_pkg::*;

  logic clk;
  logic reset;
  logic [63:0] issue_count;
  logic [63:0] stall_count;
  logic        syscall_valid;
  reg_val_t    syscall_rax;

  mop_issue_stage_if io();

  mop_issue_stage dut (
    .clk           (clk),
    .reset         (reset),
    .io            (io),
    .issue_count   (issue_count),
    .stall_count   (stall_count),
    .syscall_valid (syscall_valid),
    .syscall_rax   (syscall_rax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_mop(input string name, input micro_op_t act, input micro_op_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic micro_op_t mk(input int op, input reg_id_t d, input reg_id_t s0,
                                   input reg_id_t s1, input logic [63:0] imm,
                                   input logic [63:0] ripv);
    micro_op_t m;
    m           = '0;
    m.opcode    = 8'(op);
    m.dst       = d;
    m.src0      = s0;
    m.src1      = s1;
    m.immediate = imm;
    m.rip_val   = ripv;
    return m;
  endfunction

  // ---------------- behavioural model ----------------
  // Outstanding writes are a set of busy register numbers; the output slot is a queue
  // holding at most one expected micro-op.
  logic [63:0] mrf [16];
  bit          mbusy [int];
  micro_op_t   mslot [$];
  int          mheld = -1;
  longint unsigned micnt = 0;
  longint unsigned mscnt = 0;

  function automatic bit is_file(input reg_id_t id);
    return int'(id) < 16;
  endfunction

  function automatic bit mblocked(input reg_id_t id);
    if (is_file(id)) return mbusy.exists(int'(id));
    if (id == rsyscall) return mbusy.num() != 0;
    return 1'b0;
  endfunction

  function automatic logic [63:0] mval(input reg_id_t id, input micro_op_t m);
    if (is_file(id)) return mrf[int'(id)];
    if (id == rv8)  return 64'd8;
    if (id == rip)  return m.rip_val;
    if (id == rimm) return m.immediate;
    return 64'd0;
  endfunction

  micro_op_t iss;
  bit exp_rdy, do_issue, exp_fire;

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mrf[i] = 64'd0;
      mbusy.delete();
      mslot.delete();
      mheld = -1;
      micnt = 0;
      mscnt = 0;
      chk("rst_out_valid", 64'(io.out_valid), 64'd0);
      chk_mop("rst_out_mop", io.out_mop, '0);
      chk("rst_issue_count", issue_count, 64'd0);
      chk("rst_stall_count", stall_count, 64'd0);
    end else begin
      exp_rdy = !io.flush && !mblocked(io.in_mop.src0) && !mblocked(io.in_mop.src1) &&
                !mblocked(io.in_mop.dst) && (mslot.size() == 0 || io.out_ready);
      do_issue = io.in_valid && exp_rdy;
      exp_fire = do_issue && (io.in_mop.src0 == rsyscall || io.in_mop.src1 == rsyscall);
      chk("in_ready", 64'(io.in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(io.out_valid), 64'(mslot.size() != 0));
      if (mslot.size() != 0) chk_mop("out_mop", io.out_mop, mslot[0]);
      chk("issue_count", issue_count, micnt);
      chk("stall_count", stall_count, mscnt);
      chk("syscall_valid", 64'(syscall_valid), 64'(exp_fire));
      if (exp_fire) chk("syscall_rax", syscall_rax, mrf[0]);

      // advance to the state after the coming rising edge
      iss = io.in_mop;
      iss.src0_val = mval(io.in_mop.src0, io.in_mop);
      iss.src1_val = mval(io.in_mop.src1, io.in_mop);
      if (mslot.size() != 0 && io.flush && !io.out_ready && mheld >= 0) mbusy.delete(mheld);
      if (mslot.size() != 0 && (io.out_ready || io.flush)) begin
        void'(mslot.pop_front());
        mheld = -1;
      end
      if (io.wb_valid && is_file(io.wb_id)) begin
        mrf[int'(io.wb_id)] = io.wb_val;
        mbusy.delete(int'(io.wb_id));
      end
      if (do_issue) begin
        mslot.push_back(iss);
        micnt++;
        mheld = is_file(io.in_mop.dst) ? int'(io.in_mop.dst) : -1;
        if (is_file(io.in_mop.dst)) mbusy[int'(io.in_mop.dst)] = 1'b1;
      end
      if (io.in_valid && !exp_rdy) mscnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input bit iv, input micro_op_t m, input bit ordy,
                        input bit wv = 1'b0, input reg_id_t wid = 5'd0,
                        input logic [63:0] wval = 64'd0, input bit fl = 1'b0);
    io.in_valid  = iv;
    io.in_mop    = m;
    io.out_ready = ordy;
    io.wb_valid  = wv;
    io.wb_id     = wid;
    io.wb_val    = wval;
    io.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit iv, input micro_op_t m, input bit ordy,
                     input bit wv = 1'b0, input reg_id_t wid = 5'd0,
                     input logic [63:0] wval = 64'd0, input bit fl = 1'b0);
    set_in(iv, m, ordy, wv, wid, wval, fl);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  micro_op_t op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h, op_i, op_j;
  micro_op_t op_k, op_s, op_l, op_m, op_n, op_o, exp_c;

  initial begin
    op_a = mk(1,  rax, rbx,      rimm, 64'd5, 64'd0);
    op_b = mk(2,  rcx, rax,      rnil, 64'd0, 64'd0);
    op_c = mk(3,  rsi, rcx,      rv0,  64'd0, 64'd0);
    op_d = mk(4,  rdi, rv8,      rnil, 64'd0, 64'd0);
    op_e = mk(5,  rbp, rbx,      rimm, 64'd3, 64'd0);
    op_f = mk(6,  rdx, rnil,     rnil, 64'd0, 64'd0);
    op_g = mk(7,  rbx, rnil,     rnil, 64'd0, 64'd0);
    op_h = mk(8,  rcx, rdx,      rnil, 64'd0, 64'd0);
    op_i = mk(9,  rdx, rnil,     rnil, 64'd0, 64'd0);
    op_j = mk(10, rax, rdx,      rnil, 64'd0, 64'd0);
    op_k = mk(11, rax, rnil,     rnil, 64'd0, 64'd0);
    op_s = mk(12, rnil, rsyscall, rnil, 64'd0, 64'd0);
    op_l = mk(13, rnil, rv8,     rip,  64'd0, 64'h400000);
    op_m = mk(14, rnil, rimm,    rax,  64'h12, 64'd0);
    op_n = mk(15, rbx, rnil,     rnil, 64'd0, 64'd0);
    op_o = mk(16, rcx, rax,      rbx,  64'd0, 64'd0);

    reset = 1'b0;
    set_in(1'b0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // RAW hazard: B reads A's dst and waits for writeback of rax=7
    cyc(1, op_a, 1);
    cyc(1, op_b, 1);
    cyc(1, op_b, 1, 1, rax, 64'd7);
    cyc(1, op_b, 1);
    chk("raw_src0_val", io.out_mop.src0_val, 64'd7);
    chk("raw_stall_count", stall_count, 64'd2);
    chk("raw_issue_count", issue_count, 64'd2);
    cyc(0, op_b, 1, 1, rcx, 64'd9);
    chk("raw_drained", 64'(io.out_valid), 64'd0);

    // Backpressure: slot full for three cycles, then one op per cycle
    cyc(1, op_c, 0);
    repeat (3) cyc(1, op_d, 0);
    exp_c = op_c;
    exp_c.src0_val = 64'd9;
    chk_mop("bp_hold", io.out_mop, exp_c);
    chk("bp_in_ready", 64'(io.in_ready), 64'd0);
    chk("bp_stall_count", stall_count, 64'd5);
    cyc(1, op_d, 1);
    chk("bp_d_src0", io.out_mop.src0_val, 64'd8);
    cyc(1, op_e, 1);
    chk("bp_e_opcode", 64'(io.out_mop.opcode), 64'd5);
    chk("bp_e_src1", io.out_mop.src1_val, 64'd3);
    chk("bp_issue_count", issue_count, 64'd5);
    cyc(0, op_e, 1, 1, rsi, 64'h11);
    cyc(0, op_e, 1, 1, rdi, 64'h22);
    cyc(0, op_e, 1, 1, rbp, 64'h33);

    // Flush while execute is stalled: rdx released, no issue in the flush cycle
    cyc(1, op_f, 0);
    cyc(1, op_g, 0, 0, rax, 64'd0, 1);
    chk("flush_out_valid", 64'(io.out_valid), 64'd0);
    chk("flush_issue_count", issue_count, 64'd6);
    chk("flush_stall_count", stall_count, 64'd6);
    cyc(1, op_h, 1);
    chk("flush_rdx_free", 64'(io.out_mop.opcode), 64'd8);
    cyc(0, op_h, 1, 1, rcx, 64'h44);

    // Flush in the cycle execute takes the op: rdx stays busy until writeback
    cyc(1, op_i, 0);
    cyc(0, op_i, 1, 0, rax, 64'd0, 1);
    cyc(1, op_j, 1);
    cyc(1, op_j, 1, 1, rdx, 64'h55);
    cyc(1, op_j, 1);
    chk("flushc_src0", io.out_mop.src0_val, 64'h55);
    chk("flushc_stall_count", stall_count, 64'd8);
    cyc(0, op_j, 1, 1, rax, 64'h66);

    // Syscall waits for rax, then fires once with the written-back value
    cyc(1, op_k, 1);
    set_in(1, op_s, 1);
    #2 chk("sys_stall_quiet", 64'(syscall_valid), 64'd0);
    tick();
    set_in(1, op_s, 1, 1, rax, 64'd60);
    #2 chk("sys_wb_quiet", 64'(syscall_valid), 64'd0);
    tick();
    set_in(1, op_s, 1);
    #2 chk("sys_fire", 64'(syscall_valid), 64'd1);
    chk("sys_rax", syscall_rax, 64'd60);
    tick();
    chk("sys_issue_count", issue_count, 64'd11);
    chk("sys_stall_count", stall_count, 64'd10);
    cyc(0, op_s, 1);

    // Pseudo-register sources; writeback to rimm is ignored
    cyc(1, op_l, 0);
    chk("imm_rv8", io.out_mop.src0_val, 64'd8);
    chk("imm_rip", io.out_mop.src1_val, 64'h400000);
    cyc(0, op_l, 1, 1, rimm, 64'hdead);
    cyc(1, op_m, 1);
    chk("imm_rimm", io.out_mop.src0_val, 64'h12);
    chk("imm_rax_kept", io.out_mop.src1_val, 64'd60);
    cyc(0, op_m, 1);

    // Reset in the middle of a held op
    cyc(1, op_n, 0);
    chk("pre_rst_valid", 64'(io.out_valid), 64'd1);
    set_in(0, op_n, 0);
    #2 reset = 1'b0;
    #1 chk("async_rst_valid", 64'(io.out_valid), 64'd0);
    chk("async_rst_count", issue_count, 64'd0);
    tick();
    reset = 1'b1;
    cyc(1, op_o, 1);
    chk("post_rst_valid", 64'(io.out_valid), 64'd1);
    chk("post_rst_rax", io.out_mop.src0_val, 64'd0);
    chk("post_rst_count", issue_count, 64'd1);
    cyc(0, op_o, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
